mul66_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 66x66 pipelined multiplier (high-half result, product[127:64]) between two requesters.
- Each requester has its own valid/ready operand port and its own buffered result port.
- Tags every issued operation and steers each returned result into the owning requester's result FIFO.
- Uses credits so the non-stallable multiplier pipeline never overflows a result FIFO.

---
 rtl/mul66_rr_sched.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mul66_rr_sched.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul66_rr_sched.sv
// -----------------------------------------------------------------------------
// mul66_rr_sched
//
// Shares one externally supplied 66x66 pipelined multiplier (high half of the
// product, bits [127:64]) between two requesters. Each accepted operation is
// tagged with its requester id. The tag travels down a shift register that is
// MUL_LAT deep, in step with the multiplier pipeline. When the tag reaches the
// end, mul_res is written into that requester's result FIFO.
//
// Credits: a requester may issue only while inflight_N + count_N < RSP_DEPTH.
// The multiplier cannot stall, so this credit check is what keeps a result
// FIFO from ever overflowing.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready/a/b       operand port of requester N (N = 0, 1)
//   rspN_valid/ready/data      result port of requester N, product[127:64]
//   mul_a, mul_b               registered operands driven to the multiplier
//   mul_res                    multiplier result, MUL_LAT cycles after issue
//   stat_issue0/1, stat_stall  saturating statistics counters
//                              (present only with MUL66_RR_SCHED_STATS_EN)
//
// Parameters
//   MUL_LAT    multiplier latency, which is also the tag pipe depth (>= 1)
//   RSP_DEPTH  entries per result FIFO and credit limit (power of two, >= 2)
//
// Optional build macro: MUL66_RR_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module mul66_rr_sched #(
  parameter int MUL_LAT   = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [65:0] req0_a,
  input  logic [65:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [65:0] req1_a,
  input  logic [65:0] req1_b,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_data,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_data,

  output logic [65:0] mul_a,
  output logic [65:0] mul_b,
  input  logic [63:0] mul_res
`ifdef MUL66_RR_SCHED_STATS_EN
  ,
  output logic [31:0] stat_issue0,
  output logic [31:0] stat_issue1,
  output logic [31:0] stat_stall
`endif
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;   // counts run 0..RSP_DEPTH inclusive
  localparam int SW = CW + 1;   // inflight + count, no overflow

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // run_q stays low for the first cycle after reset, so ready stays low
  // throughout reset whatever the requesters drive.
  logic               run_q,  run_d;
  logic               last_q, last_d;     // 1: requester 1 was granted last
  logic [65:0]        mul_a_q, mul_a_d;
  logic [65:0]        mul_b_q, mul_b_d;
  logic               iss_v_q, iss_v_d;
  logic               iss_id_q, iss_id_d;
  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [MUL_LAT-1:0] tag_id_q, tag_id_d;

  logic [CW-1:0]      infl0_q, infl0_d, infl1_q, infl1_d;
  logic [CW-1:0]      cnt0_q,  cnt0_d,  cnt1_q,  cnt1_d;
  logic [PW-1:0]      wptr0_q, wptr0_d, wptr1_q, wptr1_d;
  logic [PW-1:0]      rptr0_q, rptr0_d, rptr1_q, rptr1_d;
  logic [63:0]        mem0_q [RSP_DEPTH];
  logic [63:0]        mem1_q [RSP_DEPTH];

  logic elig0, elig1, grant0, grant1;
  logic wr0, wr1, pop0, pop1;

  // ---------------------------------------------------------------------------
  // Credit check and round-robin grant
  // ---------------------------------------------------------------------------
  always_comb begin
    elig0  = run_q && req0_valid &&
             ((SW'(infl0_q) + SW'(cnt0_q)) < SW'(RSP_DEPTH));
    elig1  = run_q && req1_valid &&
             ((SW'(infl1_q) + SW'(cnt1_q)) < SW'(RSP_DEPTH));
    // When both are eligible, the requester not granted last time wins.
    grant0 = elig0 && (!elig1 || last_q);
    grant1 = elig1 && (!elig0 || !last_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Issue stage
  // ---------------------------------------------------------------------------
  always_comb begin
    run_d    = 1'b1;
    last_d   = last_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    iss_v_d  = 1'b0;
    iss_id_d = 1'b0;
    if (grant0) begin
      mul_a_d  = req0_a;
      mul_b_d  = req0_b;
      iss_v_d  = 1'b1;
      iss_id_d = 1'b0;
      last_d   = 1'b0;
    end else if (grant1) begin
      mul_a_d  = req1_a;
      mul_b_d  = req1_b;
      iss_v_d  = 1'b1;
      iss_id_d = 1'b1;
      last_d   = 1'b1;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  // ---------------------------------------------------------------------------
  // Tag pipe: the last stage lines up with mul_res for the same operation.
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = iss_v_q;
    tag_id_d[0] = iss_id_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  assign wr0  = tag_v_q[MUL_LAT-1] && !tag_id_q[MUL_LAT-1];
  assign wr1  = tag_v_q[MUL_LAT-1] &&  tag_id_q[MUL_LAT-1];
  assign pop0 = (cnt0_q != '0) && rsp0_ready;
  assign pop1 = (cnt1_q != '0) && rsp1_ready;

  // ---------------------------------------------------------------------------
  // Inflight counters and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    infl0_d = infl0_q;
    infl1_d = infl1_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    wptr0_d = wptr0_q;
    wptr1_d = wptr1_q;
    rptr0_d = rptr0_q;
    rptr1_d = rptr1_q;

    case ({grant0, wr0})
      2'b10:   infl0_d = infl0_q + CW'(1);
      2'b01:   infl0_d = infl0_q - CW'(1);
      default: infl0_d = infl0_q;
    endcase
    case ({grant1, wr1})
      2'b10:   infl1_d = infl1_q + CW'(1);
      2'b01:   infl1_d = infl1_q - CW'(1);
      default: infl1_d = infl1_q;
    endcase

    case ({wr0, pop0})
      2'b10:   cnt0_d = cnt0_q + CW'(1);
      2'b01:   cnt0_d = cnt0_q - CW'(1);
      default: cnt0_d = cnt0_q;
    endcase
    case ({wr1, pop1})
      2'b10:   cnt1_d = cnt1_q + CW'(1);
      2'b01:   cnt1_d = cnt1_q - CW'(1);
      default: cnt1_d = cnt1_q;
    endcase

    // RSP_DEPTH is a power of two, so the pointers wrap on their own.
    if (wr0)  wptr0_d = wptr0_q + PW'(1);
    if (wr1)  wptr1_d = wptr1_q + PW'(1);
    if (pop0) rptr0_d = rptr0_q + PW'(1);
    if (pop1) rptr1_d = rptr1_q + PW'(1);
  end

  // Data is forced to zero while the FIFO is empty. This makes the reset
  // value of rsp data zero without a reset on the storage itself.
  assign rsp0_valid = (cnt0_q != '0);
  assign rsp1_valid = (cnt1_q != '0);
  assign rsp0_data  = rsp0_valid ? mem0_q[rptr0_q] : 64'd0;
  assign rsp1_data  = rsp1_valid ? mem1_q[rptr1_q] : 64'd0;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      last_q   <= 1'b1;         // requester 0 wins the first contention
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      iss_v_q  <= 1'b0;
      iss_id_q <= 1'b0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
      infl0_q  <= '0;
      infl1_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      wptr0_q  <= '0;
      wptr1_q  <= '0;
      rptr0_q  <= '0;
      rptr1_q  <= '0;
    end else begin
      run_q    <= run_d;
      last_q   <= last_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      iss_v_q  <= iss_v_d;
      iss_id_q <= iss_id_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      infl0_q  <= infl0_d;
      infl1_q  <= infl1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      wptr0_q  <= wptr0_d;
      wptr1_q  <= wptr1_d;
      rptr0_q  <= rptr0_d;
      rptr1_q  <= rptr1_d;
    end
  end

  // FIFO storage has no reset. Stale entries are unreachable once the
  // counts are cleared.
  always_ff @(posedge clk) begin
    if (wr0) mem0_q[wptr0_q] <= mul_res;
    if (wr1) mem1_q[wptr1_q] <= mul_res;
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef MUL66_RR_SCHED_STATS_EN
  logic [31:0] st_iss0_q, st_iss0_d;
  logic [31:0] st_iss1_q, st_iss1_d;
  logic [31:0] st_stall_q, st_stall_d;

  always_comb begin
    st_iss0_d  = st_iss0_q;
    st_iss1_d  = st_iss1_q;
    st_stall_d = st_stall_q;
    if (grant0 && (st_iss0_q != 32'hFFFF_FFFF))
      st_iss0_d = st_iss0_q + 32'd1;
    if (grant1 && (st_iss1_q != 32'hFFFF_FFFF))
      st_iss1_d = st_iss1_q + 32'd1;
    if ((req0_valid || req1_valid) && !(grant0 || grant1) &&
        (st_stall_q != 32'hFFFF_FFFF))
      st_stall_d = st_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_iss0_q  <= '0;
      st_iss1_q  <= '0;
      st_stall_q <= '0;
    end else begin
      st_iss0_q  <= st_iss0_d;
      st_iss1_q  <= st_iss1_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_issue0 = st_iss0_q;
  assign stat_issue1 = st_iss1_q;
  assign stat_stall  = st_stall_q;
`else
`endif

  // ---------------------------------------------------------------------------
  // Credits guarantee a write never lands in a full FIFO.
  // ---------------------------------------------------------------------------
  a_no_ovf0: assert property (@(posedge clk) disable iff (!rst_n)
                              !(wr0 && (cnt0_q == CW'(RSP_DEPTH))));
  a_no_ovf1: assert property (@(posedge clk) disable iff (!rst_n)
                              !(wr1 && (cnt1_q == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_mul66_rr_sched.sv
module tb_mul66_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [65:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp0_data, rsp1_data;
  logic [65:0] mul_a, mul_b;
  logic [63:0] mul_res;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [65:0] TWO64 = 66'd1 << 64;

  always #5 clk = ~clk;

  mul66_rr_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_res    (mul_res)
  );

  // Behavioural multiplier: three register stages, high half of the product.
  logic [63:0] m1, m2, m3;
  always_ff @(posedge clk) begin
    m1 <= 64'(({66'd0, mul_a} * {66'd0, mul_b}) >> 64);
    m2 <= m1;
    m3 <= m2;
  end
  assign mul_res = m3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = TWO64; req0_b = 66'd1; req1_a = TWO64; req1_b = 66'd1;
    repeat (2) @(posedge clk);
    #2;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    tests_run++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
    tests_run++;
    if ({rsp0_data, rsp1_data} !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_rsp_data: got %h %h expected 0", rsp0_data, rsp1_data);
    end
    tests_run++;
    if ({mul_a, mul_b} !== 132'd0) begin
      tests_failed++;
      $display("FAIL reset_mul_ops: got %h %h expected 0", mul_a, mul_b);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single();
    bit early;
    req0_a = TWO64; req0_b = 66'd5; req0_valid = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    tests_run++;
    if (mul_a !== TWO64 || mul_b !== 66'd5) begin
      tests_failed++;
      $display("FAIL single_mul_ops: got %h %h expected %h 5", mul_a, mul_b, TWO64);
    end
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp0_valid !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL single_early: rsp0_valid high before 4 cycles, expected low");
    end
    tick();
    tests_run++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 64'd5) begin
      tests_failed++;
      $display("FAIL single_result: got v=%b d=%h expected v=1 d=5", rsp0_valid, rsp0_data);
    end
    tests_run++;
    if (rsp1_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rsp1: got %b expected 0", rsp1_valid);
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    tests_run++;
    if (rsp0_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pop: got %b expected 0", rsp0_valid);
    end
  endtask

  task automatic test_boundary();
    logic [65:0] av [3];
    logic [65:0] bv [3];
    logic [63:0] ev [3];
    av[0] = 66'd1 << 63; bv[0] = 66'd2;          ev[0] = 64'd1;
    av[1] = 66'd1 << 65; bv[1] = 66'd1 << 65;    ev[1] = 64'd0;
    // (2^66-1)^2 = 2^132 - 2^67 + 1: bits 67..131 set, bit 0 set
    av[2] = '1;          bv[2] = '1;             ev[2] = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_a = av[i]; req1_b = bv[i];
      #1;
      tests_run++;
      if (req1_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL boundary_ready%0d: got %b expected 1", i, req1_ready);
      end
      tick();
    end
    req1_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rsp1_valid !== 1'b1 || rsp1_data !== ev[i]) begin
        tests_failed++;
        $display("FAIL boundary_result%0d: got v=%b d=%h expected v=1 d=%h",
                 i, rsp1_valid, rsp1_data, ev[i]);
      end
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
    end
    tests_run++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL boundary_empty: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    logic exp0;
    for (int c = 0; c < 8; c++) begin
      req0_valid = 1'b1; req0_a = TWO64; req0_b = 66'(100 + n0);
      req1_valid = 1'b1; req1_a = TWO64; req1_b = 66'(200 + n1);
      #1;
      exp0 = ((c % 2) == 0);
      tests_run++;
      if ({req0_ready, req1_ready} !== {exp0, ~exp0}) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got %b expected %b",
                 c, {req0_ready, req1_ready}, {exp0, ~exp0});
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests_run++;
    if (n0 != 4 || n1 != 4) begin
      tests_failed++;
      $display("FAIL contention_counts: got %0d/%0d expected 4/4", n0, n1);
    end
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 64'(100 + i) ||
          rsp1_valid !== 1'b1 || rsp1_data !== 64'(200 + i)) begin
        tests_failed++;
        $display("FAIL contention_result%0d: got %b:%h %b:%h expected 1:%h 1:%h",
                 i, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
                 64'(100 + i), 64'(200 + i));
      end
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end
    tests_run++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL contention_empty: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
  endtask

  task automatic test_credit_full();
    int n0 = 0;
    int n1 = 0;
    logic exp0;
    rsp0_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req0_valid = 1'b1; req0_a = TWO64; req0_b = 66'(30 + n0);
      req1_valid = (c == 6 || c == 7); req1_a = TWO64; req1_b = 66'(40 + n1);
      #1;
      exp0 = (c < 4);
      tests_run++;
      if (req0_ready !== exp0) begin
        tests_failed++;
        $display("FAIL credit_ready0_c%0d: got %b expected %b", c, req0_ready, exp0);
      end
      if (c == 6 || c == 7) begin
        tests_run++;
        if (req1_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL credit_ready1_c%0d: got %b expected 1", c, req1_ready);
        end
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      tick();
    end
    req1_valid = 1'b0;
    tests_run++;
    if (n0 != 4) begin
      tests_failed++;
      $display("FAIL credit_accepts: got %0d expected 4", n0);
    end
    tests_run++;
    if (rsp0_data !== 64'd30) begin
      tests_failed++;
      $display("FAIL credit_head: got %h expected 1e", rsp0_data);
    end
    // Pop one entry: credit returns only in the following cycle.
    rsp0_ready = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL credit_same_cycle: got %b expected 0", req0_ready);
    end
    tick();
    rsp0_ready = 1'b0;
    req0_b = 66'd34;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL credit_next_cycle: got %b expected 1", req0_ready);
    end
    tick();
    #1;
    tests_run++;
    if (req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL credit_one_more: got %b expected 0", req0_ready);
    end
    req0_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 64'(31 + i)) begin
        tests_failed++;
        $display("FAIL credit_drain0_%0d: got %b:%h expected 1:%h",
                 i, rsp0_valid, rsp0_data, 64'(31 + i));
      end
      if (i < 2) begin
        tests_run++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 64'(40 + i)) begin
          tests_failed++;
          $display("FAIL credit_drain1_%0d: got %b:%h expected 1:%h",
                   i, rsp1_valid, rsp1_data, 64'(40 + i));
        end
      end
      rsp0_ready = 1'b1; rsp1_ready = (i < 2);
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end
    tests_run++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL credit_empty: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
  endtask

  task automatic test_stream();
    int  sent = 0;
    int  rcv = 0;
    bit  acc;
    rsp0_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      req0_valid = (sent < 10); req0_a = TWO64; req0_b = 66'(50 + sent);
      #1;
      acc = req0_valid && req0_ready;
      if (rsp0_valid) begin
        tests_run++;
        if (rsp0_data !== 64'(50 + rcv)) begin
          tests_failed++;
          $display("FAIL stream_data%0d: got %h expected %h", rcv, rsp0_data, 64'(50 + rcv));
        end
        rcv++;
      end
      tick();
      if (acc) sent++;
    end
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;
    tests_run++;
    if (sent != 10 || rcv != 10) begin
      tests_failed++;
      $display("FAIL stream_count: got sent=%0d rcv=%0d expected 10/10", sent, rcv);
    end
    repeat (6) tick();
    tests_run++;
    if (rsp0_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_extra: got rsp0_valid=%b expected 0", rsp0_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bit leaked;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_a = TWO64; req0_b = 66'(70 + i);
      #1;
      tests_run++;
      if (req0_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL midrst_issue%0d: got %b expected 1", i, req0_ready);
      end
      tick();
    end
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000 ||
        {mul_a, mul_b} !== 132'd0 || {rsp0_data, rsp1_data} !== 128'd0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got rdy=%b%b v=%b%b a=%h b=%h expected all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, mul_a, mul_b);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) leaked = 1'b1;
    end
    tests_run++;
    if (leaked) begin
      tests_failed++;
      $display("FAIL midrst_leak: discarded op delivered, expected none");
    end
    req0_valid = 1'b1; req0_a = TWO64; req0_b = 66'd77;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_new_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (rsp0_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_new_early: got %b expected 0", rsp0_valid);
    end
    tick();
    tests_run++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 64'd77) begin
      tests_failed++;
      $display("FAIL midrst_new_result: got %b:%h expected 1:4d", rsp0_valid, rsp0_data);
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_boundary();
    test_contention();
    test_credit_full();
    test_stream();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
